// File: rtl/mux2_rr_arbiter_if.sv
// Handshake and data bundle between two requesters and the shared output lane.
// master = requester side, slave = arbiter side; grant counters exist only with MUX2_ARB_GRANT_CNT_EN.
interface mux2_rr_arbiter_if #(
    parameter int W = 8
);
    logic         req_a;
    logic         req_b;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         gnt_a;
    logic         gnt_b;
    logic         sel;
    logic [W-1:0] y_data;
    logic         y_valid;
    logic         busy;
`ifdef MUX2_ARB_GRANT_CNT_EN
    logic [7:0]   gcnt_a;
    logic [7:0]   gcnt_b;
`endif

    modport master (
        output req_a, req_b, data_a, data_b,
`ifdef MUX2_ARB_GRANT_CNT_EN
        input  gcnt_a, gcnt_b,
`endif
        input  gnt_a, gnt_b, sel, y_data, y_valid, busy
    );

    modport slave (
        input  req_a, req_b, data_a, data_b,
`ifdef MUX2_ARB_GRANT_CNT_EN
        output gcnt_a, gcnt_b,
`endif
        output gnt_a, gnt_b, sel, y_data, y_valid, busy
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 lane arbiter with grant hold and bounded bursts; optional MUX2_ARB_GRANT_CNT_EN grant counters.
// Latency: request to grant 1 cycle; granted data to y_data 1 cycle.
// Backpressure: a waiting side is served after at most BURST_MAX cycles of the owner (0 = owner holds until release).
module mux2_rr_arbiter #(
    parameter int W         = 8,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux2_rr_arbiter_if.slave bus
);
    localparam int CW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_CAP = (BURST_MAX == 0) ? '0 : CW'(BURST_MAX - 1);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    state_t        state, state_nxt;
    logic          last_a, last_a_nxt;
    logic [CW-1:0] burst_cnt, cnt_nxt;
    logic          cap_a, cap_b;
    logic          entry_a, entry_b;
    logic [W-1:0]  y_data_q;
    logic          y_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_a    <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last_a    <= last_a_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = burst_cnt;
        last_a_nxt = last_a;
        case (state)
            IDLE: begin
                // On a tie the side that did not own the lane last wins.
                if (bus.req_a && (!bus.req_b || !last_a))
                    state_nxt = GNT_A;
                else if (bus.req_b)
                    state_nxt = GNT_B;
            end
            GNT_A: begin
                if (bus.req_a) begin
                    if (bus.req_b && (BURST_MAX != 0) && (burst_cnt == CNT_CAP))
                        state_nxt = GNT_B;
                    else if (burst_cnt != CNT_CAP)
                        cnt_nxt = burst_cnt + 1'b1;
                end else begin
                    state_nxt = bus.req_b ? GNT_B : IDLE;
                end
            end
            GNT_B: begin
                if (bus.req_b) begin
                    if (bus.req_a && (BURST_MAX != 0) && (burst_cnt == CNT_CAP))
                        state_nxt = GNT_A;
                    else if (burst_cnt != CNT_CAP)
                        cnt_nxt = burst_cnt + 1'b1;
                end else begin
                    state_nxt = bus.req_a ? GNT_A : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if ((state_nxt != state) && (state_nxt != IDLE)) begin
            cnt_nxt    = '0;
            last_a_nxt = (state_nxt == GNT_A);
        end
    end

    assign entry_a = (state_nxt == GNT_A) && (state != GNT_A);
    assign entry_b = (state_nxt == GNT_B) && (state != GNT_B);

    // Only cycles where the owner still requests carry a real word.
    assign cap_a = (state == GNT_A) && bus.req_a;
    assign cap_b = (state == GNT_B) && bus.req_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= cap_a || cap_b;
            if (cap_a)
                y_data_q <= bus.data_a;
            else if (cap_b)
                y_data_q <= bus.data_b;
        end
    end

    assign bus.gnt_a   = (state == GNT_A);
    assign bus.gnt_b   = (state == GNT_B);
    assign bus.sel     = (state == GNT_A);
    assign bus.busy    = (state != IDLE);
    assign bus.y_data  = y_data_q;
    assign bus.y_valid = y_valid_q;

`ifdef MUX2_ARB_GRANT_CNT_EN
    logic [7:0] gcnt_a_q, gcnt_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_a_q <= '0;
            gcnt_b_q <= '0;
        end else begin
            if (entry_a && (gcnt_a_q != 8'hFF))
                gcnt_a_q <= gcnt_a_q + 8'd1;
            if (entry_b && (gcnt_b_q != 8'hFF))
                gcnt_b_q <= gcnt_b_q + 8'd1;
        end
    end

    assign bus.gcnt_a = gcnt_a_q;
    assign bus.gcnt_b = gcnt_b_q;
`else
    logic unused_entry;
    assign unused_entry = entry_a ^ entry_b;
`endif
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter (W=8, BURST_MAX=4).
module tb_mux2_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total    = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter_if #(.W(8)) bus ();

    mux2_rr_arbiter #(.W(8), .BURST_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        logic exp_a;
        logic prev_a;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.data_a = 8'h00;
        bus.data_b = 8'h00;
        #2;
        chk("rst_gnt_a", bus.gnt_a, 0);
        chk("rst_gnt_b", bus.gnt_b, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_y_data", bus.y_data, 0);
        rst = 1'b0;

        // Single requester A: grant one edge later, data one edge after that.
        tick();
        bus.req_a  = 1'b1;
        bus.data_a = 8'h5A;
        tick();
        chk("t1_gnt_a", bus.gnt_a, 1);
        chk("t1_sel", bus.sel, 1);
        chk("t1_busy", bus.busy, 1);
        chk("t1_y_valid_early", bus.y_valid, 0);
        tick();
        chk("t1_y_data", bus.y_data, 8'h5A);
        chk("t1_y_valid", bus.y_valid, 1);
        bus.req_a = 1'b0;
        tick();
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_idle_valid", bus.y_valid, 0);
        chk("t1_y_data_hold", bus.y_data, 8'h5A);

        // Tie from reset: A first, then direct switch to B on release.
        pulse_reset();
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.data_a = 8'h11;
        bus.data_b = 8'h22;
        tick();
        chk("t2_first_a", bus.gnt_a, 1);
        tick();
        chk("t2_second_a", bus.gnt_a, 1);
        bus.req_a = 1'b0;
        tick();
        chk("t2_switch_b", bus.gnt_b, 1);
        chk("t2_switch_not_a", bus.gnt_a, 0);
        chk("t2_no_bubble", bus.busy, 1);
        tick();
        chk("t2_y_data_b", bus.y_data, 8'h22);
        chk("t2_y_valid_b", bus.y_valid, 1);
        bus.req_b = 1'b0;
        tick();
        chk("t2_idle", bus.busy, 0);

        // Both held: bursts of four alternate A,B.
        pulse_reset();
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.data_a = 8'hA1;
        bus.data_b = 8'hB2;
        prev_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_a = ((i / 4) % 2) == 0;
            chk($sformatf("t3_gnt_a_%0d", i), bus.gnt_a, exp_a);
            chk($sformatf("t3_gnt_b_%0d", i), bus.gnt_b, !exp_a);
            chk($sformatf("t3_sel_%0d", i), bus.sel, exp_a);
            if (i > 0) begin
                chk($sformatf("t3_y_valid_%0d", i), bus.y_valid, 1);
                chk($sformatf("t3_y_data_%0d", i), bus.y_data, prev_a ? 8'hA1 : 8'hB2);
            end
            prev_a = exp_a;
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        tick();
        chk("t3_idle", bus.busy, 0);

        // A alone for 10 cycles: held, counter saturates, then B is served at once.
        bus.req_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t4_gnt_a_%0d", i), bus.gnt_a, 1);
            chk($sformatf("t4_cnt_%0d", i), dut.burst_cnt, (i < 3) ? i : 3);
        end
        bus.req_b = 1'b1;
        tick();
        chk("t4_switch_b", bus.gnt_b, 1);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        tick();
        chk("t4_idle", bus.busy, 0);

        // Asynchronous reset in the middle of a B burst.
        bus.req_b  = 1'b1;
        bus.data_b = 8'h3C;
        tick();
        chk("t5_gnt_b", bus.gnt_b, 1);
        tick();
        chk("t5_y_valid", bus.y_valid, 1);
        chk("t5_y_data", bus.y_data, 8'h3C);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_gnt_b", bus.gnt_b, 0);
        chk("t5_rst_sel", bus.sel, 0);
        chk("t5_rst_y_valid", bus.y_valid, 0);
        chk("t5_rst_y_data", bus.y_data, 0);
        chk("t5_rst_busy", bus.busy, 0);
        rst = 1'b0;
        bus.req_b = 1'b0;
        tick();
        chk("t5_after_idle", bus.busy, 0);
        chk("t5_after_valid", bus.y_valid, 0);

`ifdef MUX2_ARB_GRANT_CNT_EN
        pulse_reset();
        chk("t6_gcnt_a_rst", bus.gcnt_a, 0);
        chk("t6_gcnt_b_rst", bus.gcnt_b, 0);
        for (int i = 0; i < 3; i++) begin
            bus.req_a = 1'b1;
            tick();
            bus.req_a = 1'b0;
            tick();
        end
        bus.req_b = 1'b1;
        tick();
        bus.req_b = 1'b0;
        tick();
        chk("t6_gcnt_a_3", bus.gcnt_a, 3);
        chk("t6_gcnt_b_1", bus.gcnt_b, 1);
        for (int i = 0; i < 300; i++) begin
            bus.req_a = 1'b1;
            tick();
            bus.req_a = 1'b0;
            tick();
        end
        chk("t6_gcnt_a_sat", bus.gcnt_a, 255);
        chk("t6_gcnt_b_keep", bus.gcnt_b, 1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
